// File: rtl/ex_stage.sv
// Execute stage: logic/shift/move ALU, HI/LO registers and the EX/MEM pipeline register.
// Define EX_MULT_EN to build the iterative 32x32 MULT/MULTU unit; without it those ops retire as NOPs.
module ex_stage (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_aluop,
  input  logic [2:0]  i_alusel,
  input  logic [31:0] i_reg1,
  input  logic [31:0] i_reg2,
  input  logic [4:0]  i_w_addr,
  input  logic        i_we,
  output logic        o_stall_req,
  output logic        o_ex_we,
  output logic [4:0]  o_ex_w_addr,
  output logic [31:0] o_ex_w_data,
  output logic        o_mem_we,
  output logic [4:0]  o_mem_w_addr,
  output logic [31:0] o_mem_w_data,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int unsigned DW = 32;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;

  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
  localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;

  logic [DW-1:0]   r_hi;
  logic [DW-1:0]   r_lo;
  logic [DW-1:0]   w_logic_res;
  logic [DW-1:0]   w_shift_res;
  logic [DW-1:0]   w_move_res;
  logic [DW-1:0]   w_result;
  logic [4:0]      w_shamt;
  logic            w_is_mult;
  logic            w_stall;
  logic            w_idle;
  logic            w_mult_done;
  logic [2*DW-1:0] w_product;

  assign w_shamt   = i_reg1[4:0];
  assign w_is_mult = (i_aluop == OP_MULT) || (i_aluop == OP_MULTU);

  // Single-cycle result for the non-multiply classes
  always_comb begin
    w_logic_res = '0;
    w_shift_res = '0;
    w_move_res  = '0;
    w_result    = '0;
    case (i_aluop)
      OP_OR:   w_logic_res = i_reg1 | i_reg2;
      OP_AND:  w_logic_res = i_reg1 & i_reg2;
      OP_XOR:  w_logic_res = i_reg1 ^ i_reg2;
      OP_NOR:  w_logic_res = ~(i_reg1 | i_reg2);
      default: w_logic_res = '0;
    endcase
    case (i_aluop)
      OP_SLL:  w_shift_res = i_reg2 << w_shamt;
      OP_SRL:  w_shift_res = i_reg2 >> w_shamt;
      OP_SRA:  w_shift_res = DW'($signed(i_reg2) >>> w_shamt);
      default: w_shift_res = '0;
    endcase
    case (i_aluop)
      OP_MFHI:          w_move_res = r_hi;
      OP_MFLO:          w_move_res = r_lo;
      OP_MOVN, OP_MOVZ: w_move_res = i_reg1;
      default:          w_move_res = '0;
    endcase
    case (i_alusel)
      RES_LOGIC: w_result = w_logic_res;
      RES_SHIFT: w_result = w_shift_res;
      RES_MOVE:  w_result = w_move_res;
      RES_NOP:   w_result = '0;
      default:   w_result = '0;
    endcase
  end

  assign o_ex_we      = i_we & ~w_is_mult;
  assign o_ex_w_addr  = i_w_addr;
  assign o_ex_w_data  = w_result;
  // Reset forces the hold request low even while a multiply op sits on the inputs
  assign o_stall_req  = i_rst_n & w_stall;

`ifdef EX_MULT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [4:0]      r_cnt;
  logic [2*DW-1:0] r_mcand;
  logic [DW-1:0]   r_mplr;
  logic [2*DW-1:0] r_acc;
  logic            r_neg;
  logic            w_signed;
  logic [DW-1:0]   w_mag1;
  logic [DW-1:0]   w_mag2;

  // Two's-complement magnitude of 0x80000000 is 0x80000000, which fits the unsigned 32-bit path
  assign w_signed = (i_aluop == OP_MULT);
  assign w_mag1   = (w_signed && i_reg1[DW-1]) ? DW'(~i_reg1 + 32'd1) : i_reg1;
  assign w_mag2   = (w_signed && i_reg2[DW-1]) ? DW'(~i_reg2 + 32'd1) : i_reg2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_mult) begin
          w_stall      = 1'b1;
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == 5'd31) w_next_state = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Shift-add datapath: one multiplier bit consumed per BUSY cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_neg   <= 1'b0;
    end else if (r_state == ST_IDLE && w_is_mult) begin
      r_cnt   <= '0;
      r_mcand <= {32'd0, w_mag1};
      r_mplr  <= w_mag2;
      r_acc   <= '0;
      r_neg   <= w_signed & (i_reg1[DW-1] ^ i_reg2[DW-1]);
    end else if (r_state == ST_BUSY) begin
      if (r_mplr[0]) r_acc <= r_acc + r_mcand;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt + 5'd1;
    end
  end

  assign w_idle      = (r_state == ST_IDLE);
  assign w_mult_done = (r_state == ST_DONE);
  assign w_product   = r_neg ? (~r_acc + 64'd1) : r_acc;
`else
  assign w_stall     = 1'b0;
  assign w_idle      = 1'b1;
  assign w_mult_done = 1'b0;
  assign w_product   = '0;
`endif

  // HI/LO: multiply result on completion, otherwise MTHI/MTLO writes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_mult_done) begin
      r_hi <= w_product[2*DW-1:DW];
      r_lo <= w_product[DW-1:0];
    end else if (w_idle) begin
      if (i_aluop == OP_MTHI) r_hi <= i_reg1;
      if (i_aluop == OP_MTLO) r_lo <= i_reg1;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

  // EX/MEM register; a stalled cycle hands a bubble downstream
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_we     <= 1'b0;
      o_mem_w_addr <= '0;
      o_mem_w_data <= '0;
    end else if (w_stall) begin
      o_mem_we     <= 1'b0;
      o_mem_w_addr <= '0;
      o_mem_w_data <= '0;
    end else begin
      o_mem_we     <= o_ex_we;
      o_mem_w_addr <= o_ex_w_addr;
      o_mem_w_data <= o_ex_w_data;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage; multiplier scenarios are compiled when EX_MULT_EN is defined.
module tb_ex_stage;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;

  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
  localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;

  logic        clk;
  logic        rst_n;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  w_addr;
  logic        we;
  logic        stall_req;
  logic        ex_we;
  logic [4:0]  ex_w_addr;
  logic [31:0] ex_w_data;
  logic        mem_we;
  logic [4:0]  mem_w_addr;
  logic [31:0] mem_w_data;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  ex_stage dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_aluop      (aluop),
    .i_alusel     (alusel),
    .i_reg1       (reg1),
    .i_reg2       (reg2),
    .i_w_addr     (w_addr),
    .i_we         (we),
    .o_stall_req  (stall_req),
    .o_ex_we      (ex_we),
    .o_ex_w_addr  (ex_w_addr),
    .o_ex_w_data  (ex_w_data),
    .o_mem_we     (mem_we),
    .o_mem_w_addr (mem_w_addr),
    .o_mem_w_data (mem_w_data),
    .o_hi         (hi),
    .o_lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] addr, input logic wen);
    aluop  = op;
    alusel = sel;
    reg1   = a;
    reg2   = b;
    w_addr = addr;
    we     = wen;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    issue(OP_NOP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    #12;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_w_addr !== 5'd0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_w_addr); end
    checks++; if (mem_w_data !== 32'd0) begin failures++; $display("FAIL reset_mem_data got=%h exp=0", mem_w_data); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_logic();
    logic [7:0]  ops [8];
    logic [31:0] a   [8];
    logic [31:0] b   [8];
    logic [31:0] exp [8];
    ops = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_OR, OP_AND, OP_XOR, OP_NOR};
    a   = '{32'h0000FF00, 32'h0000FF00, 32'h0000FF00, 32'h0000FF00,
            32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0};
    b   = '{32'h00FF0000, 32'h00FF0000, 32'h00FF0000, 32'h00FF0000,
            32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00};
    exp = '{32'h00FFFF00, 32'h00000000, 32'h00FFFF00, 32'hFF0000FF,
            32'hFFF0FFF0, 32'hF000F000, 32'h0FF00FF0, 32'h000F000F};
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], RES_LOGIC, a[i], b[i], 5'(i + 3), 1'b1);
      #1;
      checks++;
      if (ex_w_data !== exp[i] || ex_we !== 1'b1 || ex_w_addr !== 5'(i + 3)) begin
        failures++;
        $display("FAIL logic_ex[%0d] got=%h/%b/%0d exp=%h/1/%0d", i, ex_w_data, ex_we, ex_w_addr, exp[i], i + 3);
      end
      step();
      checks++;
      if (mem_w_data !== exp[i] || mem_we !== 1'b1 || mem_w_addr !== 5'(i + 3)) begin
        failures++;
        $display("FAIL logic_mem[%0d] got=%h/%b/%0d exp=%h/1/%0d", i, mem_w_data, mem_we, mem_w_addr, exp[i], i + 3);
      end
    end
  endtask

  task automatic test_shift();
    logic [7:0]  ops [6];
    logic [31:0] a   [6];
    logic [31:0] b   [6];
    logic [31:0] exp [6];
    ops = '{OP_SRA, OP_SRL, OP_SLL, OP_SRA, OP_SLL, OP_SRA};
    a   = '{32'd4, 32'd4, 32'd4, 32'd31, 32'h00000021, 32'd0};
    b   = '{32'h80000000, 32'h80000000, 32'h80000001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    exp = '{32'hF8000000, 32'h08000000, 32'h00000010, 32'h00000000, 32'h00000002, 32'h80000000};
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], RES_SHIFT, a[i], b[i], 5'd12, 1'b1);
      #1;
      checks++;
      if (ex_w_data !== exp[i]) begin
        failures++;
        $display("FAIL shift[%0d] got=%h exp=%h", i, ex_w_data, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_move();
    issue(OP_MTHI, RES_NOP, 32'h12345678, 32'd0, 5'd0, 1'b0);
    #1;
    checks++; if (ex_w_data !== 32'd0 || ex_we !== 1'b0) begin failures++; $display("FAIL mthi_ex got=%h/%b exp=0/0", ex_w_data, ex_we); end
    step();
    issue(OP_MFHI, RES_MOVE, 32'd0, 32'd0, 5'd5, 1'b1);
    #1;
    checks++; if (ex_w_data !== 32'h12345678) begin failures++; $display("FAIL mfhi_data got=%h exp=12345678", ex_w_data); end
    checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mfhi_hi got=%h exp=12345678", hi); end
    step();
    issue(OP_MTLO, RES_NOP, 32'hCAFEBABE, 32'd0, 5'd0, 1'b0);
    step();
    issue(OP_MFLO, RES_MOVE, 32'd0, 32'd0, 5'd6, 1'b1);
    #1;
    checks++; if (ex_w_data !== 32'hCAFEBABE || lo !== 32'hCAFEBABE) begin failures++; $display("FAIL mflo got=%h/%h exp=cafebabe", ex_w_data, lo); end
    checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mtlo_hi_kept got=%h exp=12345678", hi); end
    step();
    issue(OP_MOVZ, RES_MOVE, 32'hAAAA5555, 32'd0, 5'd8, 1'b0);
    #1;
    checks++; if (ex_we !== 1'b0 || ex_w_data !== 32'hAAAA5555) begin failures++; $display("FAIL movz_ex got=%b/%h exp=0/aaaa5555", ex_we, ex_w_data); end
    step();
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL movz_mem_we got=%b exp=0", mem_we); end
    issue(OP_MOVN, RES_MOVE, 32'h0BADF00D, 32'd1, 5'd7, 1'b1);
    step();
    checks++; if (mem_we !== 1'b1 || mem_w_addr !== 5'd7 || mem_w_data !== 32'h0BADF00D) begin
      failures++; $display("FAIL movn_mem got=%b/%0d/%h exp=1/7/0badf00d", mem_we, mem_w_addr, mem_w_data);
    end
  endtask

  task automatic test_nop_class();
    issue(OP_OR, RES_NOP, 32'hFFFFFFFF, 32'h1, 5'd9, 1'b1);
    #1;
    checks++; if (ex_w_data !== 32'd0 || ex_we !== 1'b1) begin failures++; $display("FAIL nop_class got=%h/%b exp=0/1", ex_w_data, ex_we); end
    step();
    issue(OP_OR, 3'b110, 32'hFFFFFFFF, 32'h1, 5'd9, 1'b1);
    #1;
    checks++; if (ex_w_data !== 32'd0) begin failures++; $display("FAIL unknown_class got=%h exp=0", ex_w_data); end
    step();
    issue(OP_NOP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    step();
  endtask

`ifdef EX_MULT_EN
  task automatic run_mult(input string name, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
    int n;
    logic bubble_ok;
    n = 0;
    bubble_ok = 1'b1;
    issue(op, RES_NOP, a, b, 5'd9, 1'b1);
    #1;
    checks++; if (ex_we !== 1'b0) begin failures++; $display("FAIL %s_ex_we got=%b exp=0", name, ex_we); end
    while (stall_req === 1'b1 && n < 100) begin
      n++;
      step();
      if (stall_req === 1'b1 && (mem_we !== 1'b0 || mem_w_addr !== 5'd0 || mem_w_data !== 32'd0)) bubble_ok = 1'b0;
    end
    checks++; if (n != 33) begin failures++; $display("FAIL %s_stall_cycles got=%0d exp=33", name, n); end
    checks++; if (!bubble_ok) begin failures++; $display("FAIL %s_bubble got=nonzero exp=zero", name); end
    @(posedge clk);
    #1;
    issue(OP_NOP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    #1;
    checks++; if ({hi, lo} !== exp) begin failures++; $display("FAIL %s_hilo got=%h exp=%h", name, {hi, lo}, exp); end
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL %s_idle_stall got=%b exp=0", name, stall_req); end
    step();
  endtask

  task automatic test_mult();
    run_mult("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
    run_mult("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_mult("mult_min", OP_MULT, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    run_mult("mult_min1", OP_MULT, 32'h80000000, 32'd1, 64'hFFFFFFFF_80000000);
  endtask

  task automatic test_reset_busy();
    issue(OP_MULT, RES_NOP, 32'd1000, 32'd1000, 5'd9, 1'b1);
    repeat (11) step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL rstbusy_stall got=%b exp=0", stall_req); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL rstbusy_hilo got=%h/%h exp=0/0", hi, lo); end
    checks++; if (mem_we !== 1'b0 || mem_w_addr !== 5'd0 || mem_w_data !== 32'd0) begin
      failures++; $display("FAIL rstbusy_mem got=%b/%0d/%h exp=0/0/0", mem_we, mem_w_addr, mem_w_data);
    end
    issue(OP_NOP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    checks++; if (stall_req !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++; $display("FAIL rstbusy_after got=%b/%h/%h exp=0/0/0", stall_req, hi, lo);
    end
    run_mult("multu_resume", OP_MULTU, 32'd3, 32'd5, 64'h00000000_0000000F);
  endtask
`else
  task automatic test_mult_disabled();
    issue(OP_MTHI, RES_NOP, 32'h11111111, 32'd0, 5'd0, 1'b0);
    step();
    issue(OP_MTLO, RES_NOP, 32'h22222222, 32'd0, 5'd0, 1'b0);
    step();
    issue(OP_MULT, RES_NOP, 32'hFFFFFFFD, 32'd7, 5'd9, 1'b1);
    #1;
    checks++; if (stall_req !== 1'b0 || ex_we !== 1'b0) begin failures++; $display("FAIL nomult_ex got=%b/%b exp=0/0", stall_req, ex_we); end
    step();
    checks++; if (mem_we !== 1'b0 || mem_w_data !== 32'd0) begin failures++; $display("FAIL nomult_mem got=%b/%h exp=0/0", mem_we, mem_w_data); end
    issue(OP_MULTU, RES_NOP, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 1'b1);
    repeat (3) step();
    checks++; if (hi !== 32'h11111111 || lo !== 32'h22222222 || stall_req !== 1'b0) begin
      failures++; $display("FAIL nomult_hilo got=%h/%h/%b exp=11111111/22222222/0", hi, lo, stall_req);
    end
    issue(OP_NOP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_logic();
    test_shift();
    test_move();
    test_nop_class();
`ifdef EX_MULT_EN
    test_mult();
    test_reset_busy();
`else
    test_mult_disabled();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
